// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, channel width and 3-bit {R,G,B} colour codes
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END = H_SYNC_START + H_SYNC;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END = V_SYNC_START + V_SYNC;
  localparam int COLOUR_W = 10;
  typedef enum logic [2:0] {
    BLACK   = 3'b000,
    BLUE    = 3'b001,
    GREEN   = 3'b010,
    CYAN    = 3'b011,
    RED     = 3'b100,
    MAGENTA = 3'b101,
    YELLOW  = 3'b110,
    WHITE   = 3'b111
  } colour_e;
endpackage

// File: rtl/vga_fb_scanout_if.sv
// vga_fb_scanout_if: frame-buffer read port between the scan-out (master) and the RAM (slave)
interface vga_fb_scanout_if #(
  parameter int ADDR_W = 17,
  parameter int BPC = 1
);
  logic [ADDR_W-1:0] rd_addr;
  logic [3*BPC-1:0] rd_data;
  modport master (output rd_addr, input rd_data);
  modport slave (input rd_addr, output rd_data);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-enable phase, h/v counters, raw active-low syncs, active flag and frame_start pulse
module vga_timing_gen import vga_pkg::*; #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP = vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       resetn,
  output logic       pix_en_o,
  output logic [9:0] h_o,
  output logic [9:0] v_o,
  output logic       hs_n_o,
  output logic       vs_n_o,
  output logic       active_o,
  output logic       frame_start_o
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] H_SS = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SS = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic       pix_en_q, fs_q;
  logic [9:0] h_q, v_q, h_d, v_d;
  // h wraps at the end of the line and only then steps v, which wraps at the end of the frame
  always_comb begin
    h_d = h_q == H_LAST ? 10'd0 : h_q + 10'd1;
    v_d = h_q != H_LAST ? v_q : v_q == V_LAST ? 10'd0 : v_q + 10'd1;
  end
  // pix_en alternates every clk; counters move on pixel ticks; frame_start is one clk wide on tick (0,0)
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      pix_en_q <= 1'b0;
      fs_q <= 1'b0;
      h_q <= '0;
      v_q <= '0;
    end else begin
      pix_en_q <= !pix_en_q;
      fs_q <= pix_en_q && h_q == '0 && v_q == '0;
      if (pix_en_q) begin
        h_q <= h_d;
        v_q <= v_d;
      end
    end
  assign pix_en_o = pix_en_q;
  assign h_o = h_q;
  assign v_o = v_q;
  assign hs_n_o = !(h_q >= H_SS && h_q < H_SE);
  assign vs_n_o = !(v_q >= V_SS && v_q < V_SE);
  assign active_o = h_q < H_ACT && v_q < V_ACT;
  assign frame_start_o = fs_q;
endmodule

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: frame-buffer read side; VGA timing, scaled read addresses and data/sync-aligned pins.
// Optional VGA_FB_SCANOUT_TESTPATTERN_EN adds a test_mode input that swaps RAM data for 8 colour bars.
module vga_fb_scanout import vga_pkg::*; #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP = vga_pkg::V_BP,
  parameter int SCALE_SHIFT = 1,
  parameter int BITS_PER_COLOUR = 1,
  parameter int ADDR_W = 17
) (
  input  logic                clk,
  input  logic                resetn,
  vga_fb_scanout_if.master    fb,
  output logic                frame_start,
`ifdef VGA_FB_SCANOUT_TESTPATTERN_EN
  input  logic                test_mode,
`endif
  output logic                VGA_CLK,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_BLANK_N,
  output logic                VGA_SYNC_N,
  output logic [COLOUR_W-1:0] VGA_R,
  output logic [COLOUR_W-1:0] VGA_G,
  output logic [COLOUR_W-1:0] VGA_B
);
  localparam int BPC = BITS_PER_COLOUR;
  logic              pix_en, hs_n, vs_n, active;
  logic [9:0]        h, v;
  logic [ADDR_W-1:0] addr_d, rd_addr_q;
  logic              hs0_q, vs0_q, act0_q, hs_q, vs_q, blank_n_q;
  logic [3*BPC-1:0]  pix_d, rgb_q;
  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk),
    .resetn(resetn),
    .pix_en_o(pix_en),
    .h_o(h),
    .v_o(v),
    .hs_n_o(hs_n),
    .vs_n_o(vs_n),
    .active_o(active),
    .frame_start_o(frame_start)
  );
  // each stored pixel covers a 2^SCALE_SHIFT square of screen pixels
  always_comb addr_d = ADDR_W'(v >> SCALE_SHIFT) * ADDR_W'(H_ACTIVE >> SCALE_SHIFT) + ADDR_W'(h >> SCALE_SHIFT);
`ifdef VGA_FB_SCANOUT_TESTPATTERN_EN
  logic    tm0_q;
  colour_e bar0_q;
  logic [2:0] bar_d;
  assign bar_d = 3'(32'(h) / (H_ACTIVE / 8));
  // colour bar and mode ride alongside the read so they land on the same pixel as the RAM data
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      tm0_q <= 1'b0;
      bar0_q <= BLACK;
    end else if (pix_en) begin
      tm0_q <= test_mode;
      bar0_q <= colour_e'(bar_d);
    end
  assign pix_d = !act0_q ? '0 : tm0_q ? {{BPC{bar0_q[2]}}, {BPC{bar0_q[1]}}, {BPC{bar0_q[0]}}} : fb.rd_data;
`else
  assign pix_d = act0_q ? fb.rd_data : '0;
`endif
  // stage 0 issues the read and delays raw sync/active; stage 1 captures RAM data together with them
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rd_addr_q <= '0;
      hs0_q <= 1'b1;
      vs0_q <= 1'b1;
      act0_q <= 1'b0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q <= '0;
    end else if (pix_en) begin
      if (active) rd_addr_q <= addr_d;
      hs0_q <= hs_n;
      vs0_q <= vs_n;
      act0_q <= active;
      hs_q <= hs0_q;
      vs_q <= vs0_q;
      blank_n_q <= act0_q;
      rgb_q <= pix_d;
    end
  // channel bits are repeated MSB-first until the 10-bit DAC word is full
  for (genvar i = 0; i < COLOUR_W; i++) begin : g_exp
    assign VGA_R[COLOUR_W-1-i] = rgb_q[3*BPC-1-(i%BPC)];
    assign VGA_G[COLOUR_W-1-i] = rgb_q[2*BPC-1-(i%BPC)];
    assign VGA_B[COLOUR_W-1-i] = rgb_q[BPC-1-(i%BPC)];
  end
  assign fb.rd_addr = rd_addr_q;
  assign VGA_CLK = pix_en;
  assign VGA_HS = hs_q;
  assign VGA_VS = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N = 1'b0;
endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: randomized scan-out bench against a pixel-index reference model of the display
module tb_vga_fb_scanout;
  localparam int unsigned HT = 800, VA = 8, VT = 15, FRAME = HT * VT, NPIX = 76800;
  logic clk = 1'b0, resetn = 1'b0, test_mode = 1'b0;
  logic frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [9:0] VGA_R, VGA_G, VGA_B;
  logic [2:0] mem [NPIX];
  int unsigned n = 0, checks = 0, errors = 0, hs_lo = 0, vs_lo = 0;

  vga_fb_scanout_if #(.ADDR_W(17), .BPC(1)) fb ();

  vga_fb_scanout #(.V_ACTIVE(VA), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut (
    .clk(clk),
    .resetn(resetn),
    .fb(fb),
    .frame_start(frame_start),
`ifdef VGA_FB_SCANOUT_TESTPATTERN_EN
    .test_mode(test_mode),
`endif
    .VGA_CLK(VGA_CLK),
    .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R),
    .VGA_G(VGA_G),
    .VGA_B(VGA_B)
  );

  always #5 clk = ~clk;

  function automatic int unsigned paddr(int unsigned h, int unsigned v);
    return (v / 2) * 320 + h / 2;
  endfunction

  function automatic bit is_act(int unsigned h, int unsigned v);
    return h < 640 && v < VA;
  endfunction

  // address of the most recent visible pixel at or before pixel index k
  function automatic int unsigned exp_addr(int unsigned k);
    int unsigned p, h, v;
    p = k % FRAME;
    h = p % HT;
    v = p / HT;
    if (v >= VA) return paddr(639, VA - 1);
    if (h >= 640) return paddr(639, v);
    return paddr(h, v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at edge %0d", nm, act, exp, n);
    end
  endtask

  task automatic wait_n(input int unsigned t);
    for (int i = 0; i < 200000 && n != t; i++) @(negedge clk);
    checks++;
    if (n != t) begin
      errors++;
      $display("FAIL wait_edge got %0d expected %0d", n, t);
    end
  endtask

  // edge counter since reset release plus a latency-1 RAM; rd_data is garbage whenever it must be ignored
  always @(posedge clk or negedge resetn)
    if (!resetn) n = 0;
    else begin
      n = n + 1;
      if (n % 2 == 1 && n >= 3 && is_act(((n / 2 - 1) % FRAME) % HT, ((n / 2 - 1) % FRAME) / HT))
        fb.rd_data <= fb.rd_addr < 17'(NPIX) ? mem[fb.rd_addr] : 3'd0;
      else
        fb.rd_data <= 3'($urandom);
    end

  // after edge n: tick k = n/2-1 has issued its read, pins show pixel k-1
  always @(negedge clk) begin : compare
    int unsigned k, h, v;
    logic [2:0] c;
    logic e_hs, e_vs, e_bl;
    if (n == 0) begin
      hs_lo = 0;
      vs_lo = 0;
    end
    if (n >= 2 && n < 1602 && !VGA_HS) hs_lo++;
    if (n >= 2 && n < 24002 && !VGA_VS) vs_lo++;
    k = n / 2 - 1;
    e_hs = 1'b1;
    e_vs = 1'b1;
    e_bl = 1'b0;
    c = 3'd0;
    if (n >= 4) begin
      h = ((k - 1) % FRAME) % HT;
      v = ((k - 1) % FRAME) / HT;
      e_hs = !(h >= 656 && h < 752);
      e_vs = !(v >= VA + 2 && v < VA + 4);
      e_bl = is_act(h, v);
      c = !e_bl ? 3'd0 : test_mode ? 3'(h / 80) : mem[paddr(h, v)];
    end
    chk("VGA_CLK", VGA_CLK, n % 2);
    chk("frame_start", frame_start, n >= 2 && n % 2 == 0 && k % FRAME == 0);
    chk("rd_addr", fb.rd_addr, n >= 2 ? exp_addr(k) : 0);
    chk("VGA_HS", VGA_HS, e_hs);
    chk("VGA_VS", VGA_VS, e_vs);
    chk("VGA_BLANK_N", VGA_BLANK_N, e_bl);
    chk("VGA_SYNC_N", VGA_SYNC_N, 0);
    chk("VGA_R", VGA_R, {10{c[2]}});
    chk("VGA_G", VGA_G, {10{c[1]}});
    chk("VGA_B", VGA_B, {10{c[0]}});
  end

  task automatic chk_reset_pins();
    chk("rst_VGA_CLK", VGA_CLK, 0);
    chk("rst_rd_addr", fb.rd_addr, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_VGA_HS", VGA_HS, 1);
    chk("rst_VGA_VS", VGA_VS, 1);
    chk("rst_VGA_BLANK_N", VGA_BLANK_N, 0);
    chk("rst_VGA_RGB", {VGA_R, VGA_G, VGA_B}, 0);
  endtask

  initial begin
    for (int a = 0; a < int'(NPIX); a++) mem[a] = 3'(a);
    repeat (3) @(negedge clk);
    chk_reset_pins();
    resetn = 1'b1;
    wait_n(2);
    chk("fs_first", frame_start, 1);
    chk("addr_h0_v0", fb.rd_addr, 0);
    wait_n(4);
    chk("addr_h1_v0", fb.rd_addr, 0);
    wait_n(6);
    chk("addr_h2_v0", fb.rd_addr, 1);
    wait_n(12);
    chk("h4_R", VGA_R, 10'h000);
    chk("h4_G", VGA_G, 10'h3ff);
    chk("h4_B", VGA_B, 10'h000);
    wait_n(1404);
    chk("h700_blank", VGA_BLANK_N, 0);
    chk("h700_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    chk("h700_hs", VGA_HS, 0);
    wait_n(1602);
    chk("hs_low_clks", hs_lo, 192);
    wait_n(1604);
    chk("v1h0_blank", VGA_BLANK_N, 1);
    wait_n(1616);
    chk("v1h6_rgb", {VGA_R, VGA_G, VGA_B}, {10'h000, 10'h3ff, 10'h3ff});
    wait_n(3202);
    chk("addr_h0_v2", fb.rd_addr, 320);
    wait_n(12480);
    chk("addr_last", fb.rd_addr, 1279);
    wait_n(13000 + $urandom_range(0, 999));
    #2 resetn = 1'b0;
    #1 chk_reset_pins();
    for (int a = 0; a < int'(NPIX); a++) mem[a] = 3'($urandom);
    @(negedge clk);
    resetn = 1'b1;
    wait_n(1);
    chk("fs_after1", frame_start, 0);
    wait_n(2);
    chk("fs_after2", frame_start, 1);
    wait_n(24002);
    chk("vs_low_clks", vs_lo, 3200);
    chk("fs_wrap", frame_start, 1);
    chk("addr_wrap", fb.rd_addr, 0);
    wait_n(49000);
`ifdef VGA_FB_SCANOUT_TESTPATTERN_EN
    #2 resetn = 1'b0;
    test_mode = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    wait_n(344);
    chk("bar_h170", {VGA_R, VGA_G, VGA_B}, {10'h000, 10'h3ff, 10'h000});
    wait_n(3300);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
